// File: rtl/unified_mem_responder_if.sv
// Request/response bundle between the pipeline and the unified memory.
// Fetch and data channels share one interface; the memory side is the slave.
interface unified_mem_responder_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [2:0]  d_func3;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_func3, d_wdata,
    input  if_ready, if_rvalid, if_rdata,
    input  d_ready, d_rvalid, d_rdata, d_err
  );

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_func3, d_wdata,
    output if_ready, if_rvalid, if_rdata,
    output d_ready, d_rvalid, d_rdata, d_err
  );
endinterface

// File: rtl/unified_mem_responder.sv
// Single-ported unified RAM serving fetch and load/store one at a time.
// Data wins arbitration; the response pulse arrives LATENCY+1 edges after accept.
module unified_mem_responder #(
  parameter int ADDR_W    = 12,
  parameter int LATENCY   = 2,
  parameter int DATA_BASE = 48
) (
  input  logic clk,
  input  logic rst,
  unified_mem_responder_if.slave bus,
  output logic busy
);
  localparam int IW    = ADDR_W - 2;
  localparam int DEPTH = 1 << IW;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, state_nx;
  logic [3:0]  cnt;
  logic [31:0] mem [DEPTH];

  logic              q_d, q_we;
  logic [2:0]        q_f3;
  logic [ADDR_W-1:0] q_addr;
  logic [31:0]       q_wdata;

  logic        accept, take_d, last, idle, access;
  logic [31:0] eff;
  logic [IW-1:0] idx;
  logic [1:0]  lane;
  logic        bad_f3, misal, err;
  logic [31:0] word, shw, ld, wmask, wshift;
  logic [3:0]  bmask;
  logic        rv_if, rv_d, err_q;
  logic [31:0] rd_if, rd_d;
  logic        unused_bits;

  assign idle   = (state == IDLE);
  assign last   = (cnt == 4'(LATENCY - 1));
  assign access = (state == WAIT) && last;
  assign eff    = bus.d_addr + 32'(DATA_BASE);
  assign idx    = q_addr[ADDR_W-1:2];
  assign lane   = q_addr[1:0];
  assign unused_bits = ^{eff[31:ADDR_W], bus.if_addr[31:ADDR_W],
                         bus.if_addr[1:0]};

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    take_d   = 1'b0;
    unique case (state)
      IDLE: begin
        accept = bus.d_req | bus.if_req;
        take_d = bus.d_req;
        if (accept) state_nx = WAIT;
      end
      WAIT:    if (last) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (accept) cnt <= '0;
      else if (state == WAIT) cnt <= cnt + 4'd1;
    end
  end

  // Payload is captured only on the accept edge.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      q_d     <= take_d;
      q_we    <= take_d & bus.d_we;
      q_f3    <= take_d ? bus.d_func3 : 3'b010;
      q_addr  <= take_d ? eff[ADDR_W-1:0]
                        : {bus.if_addr[ADDR_W-1:2], 2'b00};
      q_wdata <= bus.d_wdata;
    end
  end

  always_comb begin
    bad_f3 = (q_f3 == 3'b011) || (q_f3 == 3'b110) || (q_f3 == 3'b111);
    misal  = 1'b0;
    unique case (q_f3[1:0])
      2'b01:   misal = lane[0];
      2'b10:   misal = |lane;
      default: misal = 1'b0;
    endcase
    err = q_d & (bad_f3 | misal);
  end

  always_comb begin
    word = mem[idx];
    shw  = word >> {lane, 3'b000};
    ld   = '0;
    unique case (q_f3)
      3'b000:  ld = {{24{shw[7]}}, shw[7:0]};
      3'b001:  ld = {{16{shw[15]}}, shw[15:0]};
      3'b010:  ld = word;
      3'b100:  ld = {24'd0, shw[7:0]};
      3'b101:  ld = {16'd0, shw[15:0]};
      default: ld = '0;
    endcase
  end

  always_comb begin
    bmask = 4'b1111;
    unique case (q_f3[1:0])
      2'b00:   bmask = 4'b0001 << lane;
      2'b01:   bmask = 4'b0011 << lane;
      default: bmask = 4'b1111;
    endcase
    wmask  = {{8{bmask[3]}}, {8{bmask[2]}}, {8{bmask[1]}}, {8{bmask[0]}}};
    wshift = q_wdata << {lane, 3'b000};
  end

  always_ff @(posedge clk) begin
    if (!rst && access && q_we && !err)
      mem[idx] <= (word & ~wmask) | (wshift & wmask);
  end

  // Response registers are nonzero only in the RESP cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rv_if <= 1'b0;
      rv_d  <= 1'b0;
      err_q <= 1'b0;
      rd_if <= '0;
      rd_d  <= '0;
    end else begin
      rv_if <= 1'b0;
      rv_d  <= 1'b0;
      err_q <= 1'b0;
      rd_if <= '0;
      rd_d  <= '0;
      if (access) begin
        if (q_d) begin
          rv_d  <= 1'b1;
          err_q <= err;
          rd_d  <= (err || q_we) ? 32'd0 : ld;
        end else begin
          rv_if <= 1'b1;
          rd_if <= word;
        end
      end
    end
  end

  assign bus.d_ready   = idle & ~rst;
  assign bus.if_ready  = idle & ~rst & ~bus.d_req;
  assign bus.if_rvalid = rv_if & ~rst;
  assign bus.if_rdata  = rst ? 32'd0 : rd_if;
  assign bus.d_rvalid  = rv_d & ~rst;
  assign bus.d_rdata   = rst ? 32'd0 : rd_d;
  assign bus.d_err     = err_q & ~rst;
  assign busy          = ~idle & ~rst;
endmodule

// File: tb/tb_unified_mem_responder.sv
// Scoreboard bench for unified_mem_responder: fetch, load/store sizes,
// arbitration, error responses and reset abort.
module tb_unified_mem_responder;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  typedef struct {
    bit          d;
    logic [31:0] data;
    bit          err;
  } exp_t;

  exp_t sb[$];
  exp_t me;

  unified_mem_responder_if bus();

  unified_mem_responder #(
    .ADDR_W(12),
    .LATENCY(LAT),
    .DATA_BASE(48)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.if_rvalid || bus.d_rvalid) begin
      if (sb.size() == 0) check("spurious_rvalid", 1, 0);
      else begin
        me = sb.pop_front();
        check("chan", bus.d_rvalid, me.d);
        check("rdata", me.d ? bus.d_rdata : bus.if_rdata, me.data);
        check("err", bus.d_err, me.err);
      end
    end else begin
      check("quiet_out", bus.if_rdata | bus.d_rdata | {31'd0, bus.d_err}, 0);
    end
  end

  task automatic push(bit d, logic [31:0] data, bit err);
    exp_t e;
    e.d = d; e.data = data; e.err = err;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
    sb.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(bit d, bit we, logic [2:0] f3, logic [31:0] a,
                      logic [31:0] wd, logic [31:0] exp, bit err);
    int n = 0;
    push(d, exp, err);
    if (d) begin
      bus.d_req = 1; bus.d_we = we; bus.d_func3 = f3;
      bus.d_addr = a; bus.d_wdata = wd;
    end else begin
      bus.if_req = 1; bus.if_addr = a;
    end
    do begin
      @(negedge clk);
      n++;
    end while (!(d ? bus.d_ready : bus.if_ready) && n < 50);
    check("accept", n < 50, 1);
    @(posedge clk);
    #1;
    bus.d_req = 0;
    bus.if_req = 0;
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int td, tf;
    bus.if_req = 0; bus.if_addr = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0;
    bus.d_func3 = 0; bus.d_wdata = 0;

    bus.d_req = 1; bus.if_req = 1;
    repeat (2) @(negedge clk);
    check("rst_d_ready", bus.d_ready, 0);
    check("rst_if_ready", bus.if_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rvalid", {bus.if_rvalid, bus.d_rvalid}, 0);
    @(posedge clk);
    #1;
    bus.d_req = 0; bus.if_req = 0;
    rst = 0;
    @(negedge clk);
    check("post_rst_ready", bus.d_ready, 1);
    @(posedge clk);
    #1;

    // word 0 reached through the wrapped data address
    xfer(1, 1, 3'b010, 32'hFFFF_FFD0, 32'h0050_0093, 0, 0);

    push(0, 32'h0050_0093, 0);
    bus.if_req = 1; bus.if_addr = 0;
    @(negedge clk);
    check("f_ready", bus.if_ready, 1);
    check("f_busy_acc", busy, 0);
    @(posedge clk);
    #1;
    bus.if_req = 0;
    for (int c = 2; c <= LAT + 2; c++) begin
      @(negedge clk);
      check("f_busy", busy, 1);
      check("f_rvalid", bus.if_rvalid, c == LAT + 2);
    end
    drain();

    xfer(1, 1, 3'b010, 0, 32'h8899_AABB, 0, 0);
    xfer(1, 0, 3'b000, 0, 0, 32'hFFFF_FFBB, 0);
    xfer(1, 0, 3'b100, 1, 0, 32'h0000_00AA, 0);
    xfer(1, 0, 3'b001, 2, 0, 32'hFFFF_8899, 0);
    xfer(1, 0, 3'b010, 0, 0, 32'h8899_AABB, 0);
    xfer(1, 0, 3'b010, 32'd4096, 0, 32'h8899_AABB, 0);
    xfer(0, 0, 3'b000, 3, 0, 32'h0050_0093, 0);

    xfer(1, 1, 3'b010, 4, 32'h1122_3344, 0, 0);
    xfer(1, 1, 3'b000, 5, 32'hFFFF_FFEE, 0, 0);
    xfer(1, 0, 3'b010, 4, 0, 32'h1122_EE44, 0);
    xfer(1, 1, 3'b001, 6, 32'h1234_CAFE, 0, 0);
    xfer(1, 0, 3'b010, 4, 0, 32'hCAFE_EE44, 0);
    xfer(1, 0, 3'b101, 6, 0, 32'h0000_CAFE, 0);

    xfer(1, 0, 3'b010, 2, 0, 0, 1);
    xfer(1, 1, 3'b001, 3, 32'h0000_FFFF, 0, 1);
    xfer(1, 0, 3'b010, 0, 0, 32'h8899_AABB, 0);
    xfer(1, 0, 3'b011, 0, 0, 0, 1);
    xfer(1, 0, 3'b001, 1, 0, 0, 1);
    xfer(1, 0, 3'b110, 0, 0, 0, 1);

    // simultaneous requests: data first, fetch in the next IDLE
    push(1, 32'hCAFE_EE44, 0);
    push(0, 32'h0050_0093, 0);
    bus.d_req = 1; bus.d_we = 0; bus.d_func3 = 3'b010; bus.d_addr = 4;
    bus.if_req = 1; bus.if_addr = 0;
    @(negedge clk);
    check("arb_d_ready", bus.d_ready, 1);
    check("arb_if_ready", bus.if_ready, 0);
    @(posedge clk);
    #1;
    bus.d_req = 0;
    td = 0; tf = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.d_rvalid) td = cyc;
      if (bus.if_rvalid) begin
        tf = cyc;
        break;
      end
      if (bus.if_ready && bus.if_req) begin
        @(posedge clk);
        #1;
        bus.if_req = 0;
      end
    end
    bus.if_req = 0;
    check("arb_seen", (td != 0) && (tf != 0), 1);
    check("arb_gap", tf - td, LAT + 2);
    drain();

    // reset during WAIT aborts an uncommitted store
    xfer(1, 1, 3'b010, 8, 32'h0102_0304, 0, 0);
    bus.d_req = 1; bus.d_we = 1; bus.d_func3 = 3'b010;
    bus.d_addr = 8; bus.d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("rw_ready", bus.d_ready, 1);
    @(posedge clk);
    #1;
    bus.d_req = 0;
    @(posedge clk);
    #1;
    rst = 1;
    @(negedge clk);
    check("rw_rst_ready", bus.d_ready, 0);
    check("rw_rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    check("rw_ready_back", bus.d_ready, 1);
    check("rw_busy_back", busy, 0);
    repeat (LAT + 2) @(negedge clk);
    @(posedge clk);
    #1;
    xfer(1, 0, 3'b010, 8, 0, 32'h0102_0304, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
